cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits between the dcache datapath's physical-memory side and main memory.
- Converts one 256-bit cacheline read (fill) or write (writeback) into a burst of four 64-bit beats on the memory bus.
- Returns a single-cycle `resp_o` to the cache when the whole line has moved.
- Latches the request address and write line at transaction start, so the cache may change `mem_address` internally without corrupting the burst.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
- ADDR_W, 32, address width.
- OFFSET_W, 5, line offset bits cleared on `address_o`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- address_i  in  ADDR_W  cache-side pmem address.
- read_i  in  1  cache fill request, level-held until resp_o.
- write_i  in  1  cache writeback request, level-held until resp_o.
- line_i  in  LINE_W  line to write back.
- line_o  out  LINE_W  assembled fill line.
- resp_o  out  1  one-cycle completion pulse to cache.
- address_o  out  ADDR_W  line-aligned memory address.
- read_o  out  1  memory read burst request.
- write_o  out  1  memory write burst request.
- burst_o  out  BURST_W  write beat data.
- burst_i  in  BURST_W  read beat data.
- resp_i  in  1  memory beat acknowledge; one beat per cycle it is high.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, beat counter 0, all outputs 0, including line_o and address_o. Reset mid-burst abandons the burst; no resp_o is issued.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - write_i=1 → latch {address_i[31:5],5'b0} and line_i; cnt=0; go to WR_BURST.
  - Otherwise read_i=1 → latch aligned address; cnt=0; go to RD_BURST.
  - write_i and read_i together: write wins (writeback precedes fill).
- RD_BURST:
  - read_o=1, address_o=latched address.
  - On each cycle with resp_i=1: line_o[64*cnt +: 64] <= burst_i; cnt++.
  - Cycles with resp_i=0 stall, with no capture.
  - On the capture with cnt==3 → RD_DONE. read_o drops in RD_DONE.
- RD_DONE: resp_o=1 for exactly one cycle; line_o is stable and fully valid → IDLE.
- WR_BURST:
  - write_o=1, address_o=latched address, burst_o = latched_line[64*cnt +: 64].
  - On each resp_i=1: cnt++. On resp_i with cnt==3 → WR_DONE.
- WR_DONE: resp_o=1 for one cycle, write_o=0 → IDLE.
- Holding and idle values:
  - line_o holds its last fill until the next fill's beats overwrite it.
  - burst_o=0 and address_o=0 whenever not in a burst state.
- Latency: with resp_i high every cycle, a request seen in IDLE at edge N gives read_o/write_o during cycles N+1..N+4 and resp_o in cycle N+5.
- Back-to-back requests:
  - A request still asserted in the IDLE cycle after resp_o starts a new transaction. The cache drops its request on the resp_o edge.
  - resp_i while in IDLE, RD_DONE or WR_DONE is ignored.
  - A request change during a burst is ignored.
- Beat counter is 2 bits and wraps to 0 on completion.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_PERF_EN.
- When defined:
  - Adds outputs rd_count_o[31:0] and wr_count_o[31:0], reset to 0.
  - Each increments by 1 in the cycle resp_o asserts from RD_DONE or WR_DONE respectively.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Fill, no stalls: read_i=1, address_i=32'h0000_1234. Memory returns beats 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... on consecutive resp_i. Required: address_o=32'h0000_1220; resp_o in the 5th cycle after request; line_o={4444..,3333..,2222..,1111..}.
- Writeback with stalls: write_i=1, line_i={D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,0,1. Required: burst_o=D0,D1,D1,D1,D2,D3,D3 per cycle; write_o drops after the 4th ack; exactly one resp_o.
- Simultaneous read_i=write_i=1, address_i=32'hABCD_EF40. Required: write burst first (write_o=1, read_o=0); after resp_o, with read_i still high, the fill starts to address 32'hABCD_EF40.
- Reset mid-burst: rst=0 after 2 read beats. Required: read_o=0, resp_o=0, line_o=0 immediately (asynchronous); next read completes normally with 4 fresh beats.
- Stray resp_i=1 in IDLE. Required: no state change, no resp_o, line_o unchanged.
- PERF_EN: 3 fills and 2 writebacks. Required: rd_count_o=3, wr_count_o=2; reset clears both to 0.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: splits one 256-bit fill/writeback into four 64-bit memory beats.
// Optional per-direction transaction counters are compiled in with CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor #(
    parameter int LINE_W   = 256,
    parameter int BURST_W  = 64,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [31:0]        rd_count_o,
    output logic [31:0]        wr_count_o
`endif
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   line_q, line_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        line_d    = line_q;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;

        case (state_q)
            IDLE: begin
                // Writeback goes first so a dirty victim leaves before its set is refilled.
                if (write_i) begin
                    addr_d  = address_i & ADDR_MASK;
                    wline_d = line_i;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = address_i & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = addr_q;
                if (resp_i) begin
                    line_d[BURST_W*cnt_q +: BURST_W] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = addr_q;
                burst_o   = wline_q[BURST_W*cnt_q +: BURST_W];
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign line_o = line_q;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (state_q == RD_DONE && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (state_q == WR_DONE && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor; counter checks are built when CACHELINE_ADAPTOR_PERF_EN is defined.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  address_i;
    logic         read_i, write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o, write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0]  rd_count_o, wr_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
        ,
        .rd_count_o(rd_count_o),
        .wr_count_o(wr_count_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
    task automatic txn(input logic is_wr, input logic [31:0] addr);
        address_i = addr;
        write_i   = is_wr;
        read_i    = ~is_wr;
        line_i    = {4{64'h0123_4567_89AB_CDEF}};
        burst_i   = 64'h5A5A_5A5A_5A5A_5A5A;
        resp_i    = 1'b1;
        step();
        repeat (4) step();
        chk("perf_txn_resp", resp_o, 1);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        step();
    endtask
`endif

    localparam logic [63:0] D0 = 64'hD000_0000_0000_00D0;
    localparam logic [63:0] D1 = 64'hD111_1111_1111_11D1;
    localparam logic [63:0] D2 = 64'hD222_2222_2222_22D2;
    localparam logic [63:0] D3 = 64'hD333_3333_3333_33D3;

    initial begin
        logic [63:0]  b   [4];
        logic [63:0]  c   [4];
        logic [63:0]  f   [4];
        logic [63:0]  expb[7];
        logic         pat [7];
        int           nresp;

        b    = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        c    = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
                 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003};
        f    = '{64'hF00D_0000_0000_00A0, 64'hF00D_0000_0000_00A1,
                 64'hF00D_0000_0000_00A2, 64'hF00D_0000_0000_00A3};
        expb = '{D0, D1, D1, D1, D2, D3, D3};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
        burst_i = '0; resp_i = 1'b0;
        #1 rst = 1'b0;
        step();
        step();
        chk("rst_read_o",  read_o, 0);
        chk("rst_write_o", write_o, 0);
        chk("rst_resp_o",  resp_o, 0);
        chk("rst_line_o",  line_o, 0);
        chk("rst_addr_o",  address_o, 0);
        chk("rst_burst_o", burst_o, 0);
        rst = 1'b1;
        step();

        // Fill without stalls
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t1_read_o", read_o, 1);
            chk("t1_addr_o", address_o, 32'h0000_1220);
            chk("t1_resp_early", resp_o, 0);
            resp_i  = 1'b1;
            burst_i = b[i];
            step();
        end
        chk("t1_resp_o", resp_o, 1);
        chk("t1_read_drop", read_o, 0);
        chk("t1_line_valid", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        step();
        chk("t1_resp_single", resp_o, 0);
        chk("t1_addr_idle", address_o, 0);
        chk("t1_line_hold", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Writeback with stalls
        address_i = 32'h0000_2008;
        line_i    = {D3, D2, D1, D0};
        write_i   = 1'b1;
        nresp     = 0;
        step();
        for (int k = 0; k < 7; k++) begin
            chk("t2_write_o", write_o, 1);
            chk("t2_burst_o", burst_o, expb[k]);
            chk("t2_addr_o", address_o, 32'h0000_2000);
            if (resp_o) nresp++;
            resp_i = pat[k];
            step();
        end
        write_i = 1'b0; resp_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t2_write_drop", write_o, 0);
            chk("t2_burst_idle", burst_o, 0);
            if (resp_o) nresp++;
            step();
        end
        chk("t2_resp_count", 256'(nresp), 1);

        // Simultaneous read and write: write first, then fill
        address_i = 32'hABCD_EF40;
        read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
        line_i = {4{64'h7777_0000_7777_0000}};
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_write_o", write_o, 1);
            chk("t3_read_o_low", read_o, 0);
            chk("t3_addr_o", address_o, 32'hABCD_EF40);
            step();
        end
        chk("t3_wr_resp", resp_o, 1);
        write_i = 1'b0;
        step();
        chk("t3_idle_read", read_o, 0);
        chk("t3_idle_write", write_o, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_fill_read_o", read_o, 1);
            chk("t3_fill_addr", address_o, 32'hABCD_EF40);
            burst_i = c[i];
            step();
        end
        chk("t3_rd_resp", resp_o, 1);
        read_i = 1'b0; resp_i = 1'b0;
        step();
        chk("t3_line", line_o, {c[3], c[2], c[1], c[0]});

        // Reset in the middle of a fill
        address_i = 32'h0000_0100;
        read_i = 1'b1;
        step();
        resp_i = 1'b1; burst_i = 64'hEEEE_0000_0000_0000;
        step();
        burst_i = 64'hEEEE_0000_0000_0001;
        step();
        resp_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t4_read_async", read_o, 0);
        chk("t4_resp_async", resp_o, 0);
        chk("t4_line_async", line_o, 0);
        chk("t4_addr_async", address_o, 0);
        step();
        chk("t4_resp_in_rst", resp_o, 0);
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t4_read_o", read_o, 1);
            resp_i  = 1'b1;
            burst_i = f[i];
            step();
        end
        chk("t4_resp_o", resp_o, 1);
        read_i = 1'b0; resp_i = 1'b0;
        step();
        chk("t4_line", line_o, {f[3], f[2], f[1], f[0]});

        // Stray resp_i while idle
        resp_i  = 1'b1;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_resp_o", resp_o, 0);
            chk("t5_read_o", read_o, 0);
            chk("t5_write_o", write_o, 0);
            chk("t5_line", line_o, {f[3], f[2], f[1], f[0]});
        end
        resp_i = 1'b0;
        step();

`ifdef CACHELINE_ADAPTOR_PERF_EN
        rst = 1'b0;
        #1;
        chk("perf_rd_rst", rd_count_o, 0);
        chk("perf_wr_rst", wr_count_o, 0);
        step();
        rst = 1'b1;
        step();
        txn(1'b0, 32'h0000_3000);
        txn(1'b1, 32'h0000_3020);
        txn(1'b0, 32'h0000_3040);
        txn(1'b1, 32'h0000_3060);
        txn(1'b0, 32'h0000_3080);
        chk("perf_rd_count", rd_count_o, 3);
        chk("perf_wr_count", wr_count_o, 2);
        rst = 1'b0;
        #1;
        chk("perf_rd_clear", rd_count_o, 0);
        chk("perf_wr_clear", wr_count_o, 0);
        step();
        rst = 1'b1;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
